// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard unit: the per-stage shadow record,
// forwarding-select encodings, and a constant-foldable clog2.
package hazard_pkg;

    // Records store rd at a fixed maximum width so the struct does not depend
    // on RADDR_W. The instantiating module zero-extends into this field.
    localparam int RD_MAX_W    = 8;
    localparam int FW_SEL_RF   = 0;
    localparam int FW_SEL_STG0 = 1;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                rfwe;
        logic                is_load;
    } stage_rec_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand. The lowest-numbered matching stage
// wins; sel = k+1 selects stage k, and sel = 0 selects the register file.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int RADDR_W = 5,
    parameter int N_FWD   = 3,
    parameter int SEL_W   = 2
) (
    input  logic [N_FWD-1:0]              stg_valid,
    input  logic [N_FWD-1:0]              stg_rfwe,
    input  logic [N_FWD-1:0][RADDR_W-1:0] stg_rd,
    input  logic [RADDR_W-1:0]            rs,
    input  logic                          re,
    output logic [SEL_W-1:0]              sel
);

    logic [N_FWD-1:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_FWD; k++) begin
            hit[k] = stg_valid[k] & stg_rfwe[k] & (stg_rd[k] != '0) &
                     (stg_rd[k] == rs) & re;
        end
    end

    // Scan from the oldest stage down so the youngest match is the last write.
    always_comb begin
        sel = SEL_W'(FW_SEL_RF);
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (hit[k]) sel = SEL_W'(k + 1);
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for an in-order pipeline: it shadows
// the downstream stages, resolves the ID operands, and generates stall, bubble and flush.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int N_FWD   = 3,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = clog2(N_FWD + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [RADDR_W-1:0]    id_rs1,
    input  logic [RADDR_W-1:0]    id_rs2,
    input  logic                  id_re1,
    input  logic                  id_re2,
    input  logic [RADDR_W-1:0]    id_rd,
    input  logic                  id_rfwe,
    input  logic                  id_is_load,
    input  logic                  id_redirect,
    input  logic                  ext_stall,
    input  logic [N_FWD*XLEN-1:0] stage_wd,
    input  logic [XLEN-1:0]       rf_rd1,
    input  logic [XLEN-1:0]       rf_rd2,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic [SEL_W-1:0]      fw_sel1,
    output logic [SEL_W-1:0]      fw_sel2,
    output logic [XLEN-1:0]       fw_data1,
    output logic [XLEN-1:0]       fw_data2,
    output logic [N_FWD-1:0]      stage_valid,
    output logic [CNT_W-1:0]      stall_count
);

    stage_rec_t rec_q [N_FWD];
    stage_rec_t rec_d [N_FWD];
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [N_FWD-1:0]              stg_valid, stg_rfwe;
    logic [N_FWD-1:0][RADDR_W-1:0] stg_rd;
    logic                          lu_stall;
    logic                          rec_unused;

    always_comb begin
        rec_unused = 1'b0;
        for (int k = 0; k < N_FWD; k++) begin
            stg_valid[k] = rec_q[k].valid;
            stg_rfwe[k]  = rec_q[k].rfwe;
            stg_rd[k]    = rec_q[k].rd[RADDR_W-1:0];
            rec_unused   = rec_unused ^ (^rec_q[k]);
        end
    end

    fwd_match #(.RADDR_W(RADDR_W), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_match1 (
        .stg_valid (stg_valid),
        .stg_rfwe  (stg_rfwe),
        .stg_rd    (stg_rd),
        .rs        (id_rs1),
        .re        (id_re1),
        .sel       (fw_sel1)
    );

    fwd_match #(.RADDR_W(RADDR_W), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_match2 (
        .stg_valid (stg_valid),
        .stg_rfwe  (stg_rfwe),
        .stg_rd    (stg_rd),
        .rs        (id_rs2),
        .re        (id_re2),
        .sel       (fw_sel2)
    );

    always_comb begin
        fw_data1 = rf_rd1;
        fw_data2 = rf_rd2;
        for (int k = 0; k < N_FWD; k++) begin
            if (fw_sel1 == SEL_W'(k + 1)) fw_data1 = stage_wd[k*XLEN +: XLEN];
            if (fw_sel2 == SEL_W'(k + 1)) fw_data2 = stage_wd[k*XLEN +: XLEN];
        end
    end

    // Selecting stage 0 already implies a valid, writing record. A load there
    // has no data yet, so the consumer must wait one cycle.
    assign lu_stall = id_valid & rec_q[0].is_load &
                      ((fw_sel1 == SEL_W'(FW_SEL_STG0)) |
                       (fw_sel2 == SEL_W'(FW_SEL_STG0)));

    assign stall_if_id  = lu_stall | ext_stall;
    assign bubble_id_ex = lu_stall & ~ext_stall;
    assign flush_if_id  = id_redirect & id_valid & ~lu_stall & ~ext_stall;

    always_comb begin
        rec_d         = rec_q;
        stall_count_d = stall_count_q;
        if (!ext_stall) begin
            rec_d[0].valid   = id_valid & ~lu_stall;
            rec_d[0].rd      = RD_MAX_W'(id_rd);
            rec_d[0].rfwe    = id_rfwe;
            rec_d[0].is_load = id_is_load;
            for (int k = 1; k < N_FWD; k++) rec_d[k] = rec_q[k-1];
            if (lu_stall && (stall_count_q != '1))
                stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_FWD; k++) rec_q[k] <= '0;
            stall_count_q <= '0;
        end else begin
            rec_q         <= rec_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < N_FWD; k++) stage_valid[k] = rec_q[k].valid;
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit. The stimulus queues the expected values
// for each cycle, and a negedge monitor pops them and compares them.
module tb_pipe_hazard_unit;
    import hazard_pkg::*;

    localparam int XLEN = 32, RADDR_W = 5, N_FWD = 3, SEL_W = 2;

    localparam int S_STALL = 0, S_FLUSH = 1, S_BUB = 2, S_SEL1 = 3, S_SEL2 = 4,
                   S_D1 = 5, S_D2 = 6, S_SV = 7, S_CNT = 8, S_CNT4 = 9;

    localparam logic [XLEN-1:0] WD0 = 32'hAAAA0000, WD1 = 32'hBBBB0001,
                                WD2 = 32'hCCCC0002, RF1 = 32'h11111111,
                                RF2 = 32'h22222222;

    logic clk = 1'b0, rst_n;
    logic id_valid, id_re1, id_re2, id_rfwe, id_is_load, id_redirect, ext_stall;
    logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;
    logic [N_FWD*XLEN-1:0] stage_wd;
    logic [XLEN-1:0] rf_rd1, rf_rd2;

    logic stall_if_id, flush_if_id, bubble_id_ex;
    logic [SEL_W-1:0] fw_sel1, fw_sel2;
    logic [XLEN-1:0] fw_data1, fw_data2;
    logic [N_FWD-1:0] stage_valid;
    logic [15:0] stall_count;

    logic stall4, flush4, bub4;
    logic [SEL_W-1:0] sel1_4, sel2_4;
    logic [XLEN-1:0] d1_4, d2_4;
    logic [N_FWD-1:0] sv4;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    pipe_hazard_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_rfwe(id_rfwe),
        .id_is_load(id_is_load), .id_redirect(id_redirect), .ext_stall(ext_stall),
        .stage_wd(stage_wd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .fw_sel1(fw_sel1), .fw_sel2(fw_sel2), .fw_data1(fw_data1), .fw_data2(fw_data2),
        .stage_valid(stage_valid), .stall_count(stall_count)
    );

    pipe_hazard_unit #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_rfwe(id_rfwe),
        .id_is_load(id_is_load), .id_redirect(id_redirect), .ext_stall(ext_stall),
        .stage_wd(stage_wd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .stall_if_id(stall4), .flush_if_id(flush4), .bubble_id_ex(bub4),
        .fw_sel1(sel1_4), .fw_sel2(sel2_4), .fw_data1(d1_4), .fw_data2(d2_4),
        .stage_valid(sv4), .stall_count(cnt4)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_vec = 0, n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] act(input int sig);
        case (sig)
            S_STALL: return 64'(stall_if_id);
            S_FLUSH: return 64'(flush_if_id);
            S_BUB:   return 64'(bubble_id_ex);
            S_SEL1:  return 64'(fw_sel1);
            S_SEL2:  return 64'(fw_sel2);
            S_D1:    return 64'(fw_data1);
            S_D2:    return 64'(fw_data2);
            S_SV:    return 64'(stage_valid);
            S_CNT:   return 64'(stall_count);
            S_CNT4:  return 64'(cnt4);
            default: return '1;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        logic [63:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.cyc != cyc) begin
                    n_miss++;
                    $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                             e.nm, e.cyc, cyc);
                end else begin
                    a = act(e.sig);
                    if (a !== e.val) begin
                        n_miss++;
                        $display("FAIL %s: got %0h want %0h (cycle %0d)", e.nm, a, e.val, cyc);
                    end
                end
            end
        end
    end

    task automatic expect_v(input int sig, input logic [63:0] v, input string nm);
        q.push_back('{cyc, sig, v, nm});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic redir);
        id_valid = v; id_rs1 = rs1; id_re1 = re1; id_rs2 = rs2; id_re2 = re2;
        id_rd = rd; id_rfwe = we; id_is_load = ld; id_redirect = redir;
    endtask

    initial begin : stim
        rst_n = 1'b0; ext_stall = 1'b1;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stage_wd = {WD2, WD1, WD0};
        rf_rd1 = RF1; rf_rd2 = RF2;
        tick();
        // Reset state; an external stall still reaches stall_if_id.
        expect_v(S_SV, 0, "rst_sv");     expect_v(S_CNT, 0, "rst_cnt");
        expect_v(S_SEL1, 0, "rst_sel1"); expect_v(S_D1, RF1, "rst_d1");
        expect_v(S_STALL, 1, "rst_stall_ext"); expect_v(S_BUB, 0, "rst_bub");
        tick();
        rst_n = 1'b1; ext_stall = 1'b0;
        // A: add x5
        id_set(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        // B: add x5 reading x5 -> forwarded from EX
        id_set(1, 5, 1, 0, 0, 5, 1, 0, 0);
        expect_v(S_SEL1, 1, "ex_fwd_sel1"); expect_v(S_D1, WD0, "ex_fwd_d1");
        expect_v(S_SV, 3'b001, "ex_fwd_sv"); tick();
        // C: x5 in both EX and MEM -> EX wins
        id_set(1, 5, 1, 5, 0, 0, 0, 0, 0);
        expect_v(S_SEL1, 1, "ex_prio_sel1"); expect_v(S_D1, WD0, "ex_prio_d1");
        expect_v(S_SEL2, 0, "re2_off_sel2"); expect_v(S_SV, 3'b011, "ex_prio_sv"); tick();
        // D: EX no longer writes -> MEM supplies x5
        id_set(1, 5, 1, 0, 0, 0, 0, 0, 0);
        expect_v(S_SEL1, 2, "mem_fwd_sel1"); expect_v(S_D1, WD1, "mem_fwd_d1");
        expect_v(S_SV, 3'b111, "mem_fwd_sv"); tick();
        // E/F: x0 is never forwarded
        id_set(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
        id_set(1, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_v(S_SEL1, 0, "x0_sel1"); expect_v(S_D1, RF1, "x0_d1");
        expect_v(S_STALL, 0, "x0_stall"); tick();
        // G/H/I: lw x7 then a consumer -> one load-use stall
        id_set(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
        id_set(1, 0, 0, 7, 1, 8, 1, 0, 0);
        expect_v(S_STALL, 1, "lu_stall"); expect_v(S_BUB, 1, "lu_bub");
        expect_v(S_CNT, 0, "lu_cnt0"); tick();
        expect_v(S_STALL, 0, "lu_after_stall"); expect_v(S_BUB, 0, "lu_after_bub");
        expect_v(S_SEL2, 2, "lu_after_sel2"); expect_v(S_D2, WD1, "lu_after_d2");
        expect_v(S_CNT, 1, "lu_cnt1"); expect_v(S_SV, 3'b110, "lu_after_sv"); tick();
        // J/K/L: branch on a load result -> flush deferred by one cycle
        id_set(1, 0, 0, 0, 0, 9, 1, 1, 0); tick();
        id_set(1, 9, 1, 0, 0, 0, 0, 0, 1);
        expect_v(S_FLUSH, 0, "br_lu_flush"); expect_v(S_STALL, 1, "br_lu_stall"); tick();
        expect_v(S_FLUSH, 1, "br_flush"); expect_v(S_STALL, 0, "br_stall");
        expect_v(S_SEL1, 2, "br_sel1"); expect_v(S_CNT, 2, "br_cnt"); tick();
        // M/N/O: fill the pipe, youngest is lw x12
        id_set(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
        id_set(1, 0, 0, 0, 0, 11, 1, 0, 0); tick();
        id_set(1, 0, 0, 0, 0, 12, 1, 1, 0); tick();
        // P/Q/R: external stall overrides the load-use stall and redirect
        ext_stall = 1'b1;
        id_set(1, 12, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            expect_v(S_SV, 3'b111, "ext_sv"); expect_v(S_CNT, 2, "ext_cnt");
            expect_v(S_BUB, 0, "ext_bub"); expect_v(S_STALL, 1, "ext_stall");
            expect_v(S_FLUSH, 0, "ext_flush");
            tick();
        end
        // S: external stall released, load-use still pending
        ext_stall = 1'b0;
        expect_v(S_BUB, 1, "post_ext_bub"); expect_v(S_FLUSH, 0, "post_ext_flush");
        expect_v(S_CNT, 2, "post_ext_cnt"); tick();
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_v(S_CNT, 3, "post_ext_cnt3"); tick();
        // 20 more load-use stalls: the 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            id_set(1, 0, 0, 0, 0, 13, 1, 1, 0); tick();
            id_set(1, 13, 1, 0, 0, 0, 0, 0, 0);
            if (i == 0) expect_v(S_STALL, 1, "sat_loop_stall");
            tick();
        end
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_v(S_CNT4, 15, "sat_cnt4"); expect_v(S_CNT, 23, "sat_cnt16"); tick();
        // Reset asserted while a load-use stall is pending
        id_set(1, 0, 0, 0, 0, 13, 1, 1, 0); tick();
        id_set(1, 13, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        expect_v(S_SV, 0, "midrst_sv"); expect_v(S_CNT, 0, "midrst_cnt");
        expect_v(S_CNT4, 0, "midrst_cnt4"); expect_v(S_STALL, 0, "midrst_stall");
        expect_v(S_BUB, 0, "midrst_bub");
        tick();
        rst_n = 1'b1;
        id_set(1, 0, 0, 0, 0, 14, 1, 0, 0);
        expect_v(S_SV, 0, "postrst_sv0"); tick();
        id_set(1, 14, 1, 0, 0, 0, 0, 0, 0);
        expect_v(S_SV, 3'b001, "postrst_sv1"); expect_v(S_SEL1, 1, "postrst_sel1");
        expect_v(S_CNT, 0, "postrst_cnt"); tick();
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_vec++; n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RADDR_W, default 5, register-index width.
REQ-003 SHALL have parameter N_FWD, default 3, tracked downstream stages (0=EX, 1=MEM, 2=WB); legal range 1..7.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL derive SEL_W = clog2(N_FWD+1).
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a live instruction.
- id_rs1, id_rs2  in  RADDR_W  ID source indices.
- id_re1, id_re2  in  1  ID reads rs1/rs2.
- id_rd  in  RADDR_W  ID destination.
- id_rfwe  in  1  ID instruction writes RF.
- id_is_load  in  1  ID instruction's result comes from data memory.
- id_redirect  in  1  branch/jump resolved taken in ID.
- ext_stall  in  1  memory not ready; freeze whole pipe.
- stage_wd  in  N_FWD*XLEN  write-back value per tracked stage; slice k = stage k.
- rf_rd1, rf_rd2  in  XLEN  raw RF read data.
- stall_if_id  out  1  hold PC and IF/ID.
- flush_if_id  out  1  squash IF/ID contents.
- bubble_id_ex  out  1  load ID/EX with a bubble.
- fw_sel1, fw_sel2  out  SEL_W  0 = RF, k = stage k-1.
- fw_data1, fw_data2  out  XLEN  resolved operands.
- stage_valid  out  N_FWD  shadow valid per stage.
- stall_count  out  CNT_W  load-use stall cycles.

Function
REQ-007 SHALL keep a shadow record per stage k: valid, rd, rfwe, is_load.
REQ-008 SHALL, on each clk edge with ext_stall=0, shift records k to k+1, drop stage N_FWD-1, load stage 0 from ID (valid = id_valid & ~lu_stall).
REQ-009 SHALL hold all records unchanged while ext_stall=1.
REQ-010 SHALL match stage k for operand n when valid & rfwe & rd!=0 & rd==id_rsn & id_ren.
REQ-011 SHALL give the lowest-k matching stage priority; no match or rs=0 gives fw_sel=0.
REQ-012 SHALL drive fw_data from rf_rd or stage_wd slice per fw_sel, combinationally, same cycle.
REQ-013 SHALL assert lu_stall when id_valid and stage 0 is_load matches either operand; for N_FWD=1 a load match in stage 0 still stalls.
REQ-014 SHALL drive stall_if_id = lu_stall | ext_stall and bubble_id_ex = lu_stall & ~ext_stall.
REQ-015 SHALL drive flush_if_id = id_redirect & id_valid & ~lu_stall & ~ext_stall.
REQ-016 SHALL apply priority ext_stall > lu_stall > redirect; a suppressed redirect is re-evaluated next cycle with forwarded operands.
REQ-017 SHALL increment stall_count each edge lu_stall=1 and ext_stall=0, saturating at all-ones.
REQ-018 SHALL have zero-cycle latency on every output except stage_valid, stall_count (registered).

Reset
REQ-019 SHALL, with rst_n=0, asynchronously clear all records and stall_count; outputs then: stage_valid=0, fw_sel=0, fw_data=rf_rd, stall_if_id=ext_stall, bubble/flush per REQ-014/015 with empty records.
REQ-020 SHALL, on reset mid-stall, discard pending bubbles; first post-reset edge loads stage 0 from ID normally.

Structure
REQ-021 SHALL place the stage-record struct, fw_sel encoding constants and a clog2 function in package hazard_pkg.
REQ-022 SHALL implement the priority matcher as sub-module fwd_match, instantiated once per operand.

Verification
REQ-023 SHALL cover: EX add x5 rfwe, ID reads rs1=x5 -> fw_sel1=1, fw_data1=stage_wd[0]; same x5 also in MEM -> still sel 1.
REQ-024 SHALL cover: EX lw x7, ID add rs2=x7 -> one cycle stall_if_id=1, bubble_id_ex=1, stall_count 0->1; next cycle fw_sel2=2.
REQ-025 SHALL cover: rd=x0 rfwe=1 in EX, ID rs1=x0 -> fw_sel1=0, fw_data1=rf_rd1, no stall.
REQ-026 SHALL cover: beq with load-use hazard and id_redirect=1 -> flush_if_id=0 that cycle, =1 next cycle.
REQ-027 SHALL cover: ext_stall=1 for 3 cycles with EX/MEM/WB valid -> stage_valid=3'b111 held, stall_count unchanged, bubble_id_ex=0.
REQ-028 SHALL cover: CNT_W=4, 20 load-use stalls -> stall_count=15; rst_n low mid-stall -> stage_valid=0, stall_count=0 immediately.
